// File: rtl/ucsbece154b_nway_hazard_unit.sv
// N-wide in-order issue and hazard unit: longest-prefix issue selection, internal
// E/M/W tracking, cross-slot forwarding selects, load-use stall and mispredict squash.
module ucsbece154b_nway_hazard_unit #(
  parameter int N         = 2,
  parameter int MEM_PORTS = 1,
  localparam int SW = $clog2(N),
  localparam int FW = SW + 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    valid_d_i,
  input  logic [5*N-1:0]  rs1_d_i,
  input  logic [5*N-1:0]  rs2_d_i,
  input  logic [5*N-1:0]  rd_d_i,
  input  logic [N-1:0]    regwrite_d_i,
  input  logic [N-1:0]    load_d_i,
  input  logic [N-1:0]    mem_d_i,
  input  logic [N-1:0]    ctrl_d_i,
  input  logic            mispredict_i,
  input  logic [SW-1:0]   mispredict_slot_i,
  output logic [N-1:0]    issue_mask_o,
  output logic [SW:0]     issue_count_o,
  output logic            stall_f_o,
  output logic            stall_d_o,
  output logic [N-1:0]    kill_e_o,
  output logic [FW*N-1:0] fwd_a_e_o,
  output logic [FW*N-1:0] fwd_b_e_o,
  output logic [N-1:0]    regwrite_w_o
);

  logic [4:0] rs1D [N];
  logic [4:0] rs2D [N];
  logic [4:0] rdD  [N];

  logic [N-1:0] validE, regwriteE, loadE;
  logic [4:0]   rdE  [N];
  logic [4:0]   rs1E [N];
  logic [4:0]   rs2E [N];

  logic [N-1:0] validM, regwriteM;
  logic [4:0]   rdM [N];

  logic [N-1:0] validW, regwriteW;
  logic [4:0]   rdW [N];

  logic [N-1:0]    issueMask;
  logic [SW:0]     issueCount;
  logic [N-1:0]    killE;
  logic [FW*N-1:0] fwdA, fwdB;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign rs1D[g] = rs1_d_i[5*g +: 5];
    assign rs2D[g] = rs2_d_i[5*g +: 5];
    assign rdD[g]  = rd_d_i[5*g +: 5];
  end

  // Once any slot fails, prefixOk stays low so the mask is always a prefix.
  always_comb begin
    logic slotOk;
    logic prefixOk;
    int   memUsed;
    slotOk     = 1'b0;
    prefixOk   = ~mispredict_i;
    memUsed    = 0;
    issueMask  = '0;
    issueCount = '0;
    for (int unsigned i = 0; i < N; i++) begin
      slotOk = valid_d_i[i];
      if (mem_d_i[i]) memUsed = memUsed + 1;
      if (memUsed > MEM_PORTS) slotOk = 1'b0;
      for (int unsigned j = 0; j < i; j++) begin
        if (regwrite_d_i[j] && rdD[j] != 5'd0) begin
          if (rdD[j] == rs1D[i] || rdD[j] == rs2D[i]) slotOk = 1'b0;
          if (regwrite_d_i[i] && rdD[j] == rdD[i])   slotOk = 1'b0;
        end
        if (ctrl_d_i[j]) slotOk = 1'b0;
      end
      for (int unsigned k = 0; k < N; k++) begin
        if (validE[k] && loadE[k] && regwriteE[k] && rdE[k] != 5'd0 &&
            (rdE[k] == rs1D[i] || rdE[k] == rs2D[i]))
          slotOk = 1'b0;
      end
      prefixOk     = prefixOk & slotOk;
      issueMask[i] = prefixOk;
      issueCount   = issueCount + {{SW{1'b0}}, prefixOk};
    end
  end

  always_comb begin
    killE = '0;
    for (int unsigned k = 0; k < N; k++)
      killE[k] = mispredict_i && (k > 32'(mispredict_slot_i));
  end

  // W candidates are scanned first and M last, each oldest-to-youngest, so later
  // matches override earlier ones: M beats W, and the youngest slot wins per stage.
  always_comb begin
    logic [FW-1:0] selA, selB;
    selA = '0;
    selB = '0;
    fwdA = '0;
    fwdB = '0;
    for (int unsigned s = 0; s < N; s++) begin
      selA = '0;
      selB = '0;
      if (validE[s] && !killE[s]) begin
        for (int unsigned w = 0; w < N; w++) begin
          if (validW[w] && regwriteW[w] && rdW[w] != 5'd0) begin
            if (rdW[w] == rs1E[s]) selA = {1'b1, 1'b1, SW'(w)};
            if (rdW[w] == rs2E[s]) selB = {1'b1, 1'b1, SW'(w)};
          end
        end
        for (int unsigned m = 0; m < N; m++) begin
          if (validM[m] && regwriteM[m] && rdM[m] != 5'd0) begin
            if (rdM[m] == rs1E[s]) selA = {1'b1, 1'b0, SW'(m)};
            if (rdM[m] == rs2E[s]) selB = {1'b1, 1'b0, SW'(m)};
          end
        end
      end
      fwdA[FW*s +: FW] = selA;
      fwdB[FW*s +: FW] = selB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      validE    <= '0;
      regwriteE <= '0;
      loadE     <= '0;
      validM    <= '0;
      regwriteM <= '0;
      validW    <= '0;
      regwriteW <= '0;
    end else begin
      validE    <= valid_d_i & issueMask;
      regwriteE <= regwrite_d_i;
      loadE     <= load_d_i;
      validM    <= validE & ~killE;
      regwriteM <= regwriteE;
      validW    <= validM;
      regwriteW <= regwriteM;
    end
  end

  // Register specifiers are only meaningful alongside a set valid bit.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N; i++) begin
      rdE[i]  <= rdD[i];
      rs1E[i] <= rs1D[i];
      rs2E[i] <= rs2D[i];
      rdM[i]  <= rdE[i];
      rdW[i]  <= rdM[i];
    end
  end

  assign issue_mask_o  = issueMask;
  assign issue_count_o = issueCount;
  assign stall_f_o     = (issueCount == '0) & (|valid_d_i) & ~mispredict_i;
  assign stall_d_o     = (issueCount == '0) & (|valid_d_i) & ~mispredict_i;
  assign kill_e_o      = killE;
  assign fwd_a_e_o     = fwdA;
  assign fwd_b_e_o     = fwdB;
  assign regwrite_w_o  = validW & regwriteW;

endmodule
